// File: rtl/sram_bus_fifo_bridge.sv
// sram_bus_fifo_bridge: AVR external data-memory responder exposing a
// 4-register window (DATA, STATUS, RX_COUNT, CTRL) over two byte FIFOs.
//   RX: fabric producer -> AVR (read DATA pops)
//   TX: AVR -> fabric consumer (write DATA pushes)
// Optional build macro SRAM_BRIDGE_BLOCKING_EN: empty DATA reads and full
// DATA writes stall the master on bus_wait instead of returning 0 / dropping.
// Without the macro they complete normally and set the sticky
// rx_underflow / tx_overflow flags.

module sram_bus_fifo_bridge #(
    parameter int RX_DEPTH = 16,
    parameter int TX_DEPTH = 16,
    parameter int READ_WS  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] bus_a,
    input  logic       bus_cs,
    input  logic       bus_oe,
    input  logic       bus_we,
    input  logic [7:0] bus_d_in,
    output logic [7:0] bus_d_out,
    output logic       bus_wait,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       irq
);

    localparam int RX_AW   = $clog2(RX_DEPTH);
    localparam int TX_AW   = $clog2(TX_DEPTH);
    localparam int RX_CW   = RX_AW + 1;
    localparam int TX_CW   = TX_AW + 1;
    localparam int WS_W    = $clog2(READ_WS + 1);
    // With a single wait state the IDLE cycle is itself the last wait cycle;
    // RD_WAIT is only entered then when a blocking read has to park.
    localparam bit WS_ONE  = (READ_WS == 1);
    localparam int WS_INIT = (READ_WS == 1) ? 1 : (READ_WS - 1);

    localparam logic [1:0] A_DATA   = 2'd0;
    localparam logic [1:0] A_STATUS = 2'd1;
    localparam logic [1:0] A_COUNT  = 2'd2;
    localparam logic [1:0] A_CTRL   = 2'd3;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_WAIT  = 2'd1,
        RD_DONE  = 2'd2,
        WR_STALL = 2'd3
    } state_t;

    state_t state_r;
    state_t next_state_s;

    // FIFO storage and pointers
    logic [7:0]       rx_mem [RX_DEPTH];
    logic [7:0]       tx_mem [TX_DEPTH];
    logic [RX_AW-1:0] rx_wr_ptr_r;
    logic [RX_AW-1:0] rx_rd_ptr_r;
    logic [RX_CW-1:0] rx_count_r;
    logic [TX_AW-1:0] tx_wr_ptr_r;
    logic [TX_AW-1:0] tx_rd_ptr_r;
    logic [TX_CW-1:0] tx_count_r;

    // Register window state
    logic [1:0]       ctrl_r;
    logic             rx_underflow_r;
    logic             tx_overflow_r;
    logic             irq_r;
    logic [7:0]       bus_d_out_r;
    logic [1:0]       rd_addr_r;
    logic [WS_W-1:0]  ws_cnt_r;
`ifdef SRAM_BRIDGE_BLOCKING_EN
    logic [7:0]       wr_data_r;
`endif

    // Decoded controls
    logic             wait_s;
    logic             rd_fire_s;
    logic             wr_fire_s;
    logic             stall_push_s;
    logic             rd_ok_s;
    logic [1:0]       rd_addr_s;
    logic [7:0]       rd_val_s;
    logic             rx_empty_s;
    logic             rx_full_s;
    logic             tx_empty_s;
    logic             tx_full_s;
    logic             rx_push_s;
    logic             rx_pop_s;
    logic             tx_push_s;
    logic             tx_pop_s;
    logic [7:0]       tx_push_data_s;
    logic             flush_s;
    logic             unf_set_s;
    logic             ovf_set_s;
    logic             sticky_clr_s;

    assign rx_empty_s = (rx_count_r == {RX_CW{1'b0}});
    assign rx_full_s  = (rx_count_r == RX_CW'(RX_DEPTH));
    assign tx_empty_s = (tx_count_r == {TX_CW{1'b0}});
    assign tx_full_s  = (tx_count_r == TX_CW'(TX_DEPTH));

    assign in_ready  = ~rst & ~rx_full_s;
    assign out_valid = ~rst & ~tx_empty_s;
    assign out_data  = tx_mem[tx_rd_ptr_r];
    assign bus_d_out = bus_d_out_r;
    assign irq       = irq_r;
    // Reset releases the master in the very cycle it is sampled.
    assign bus_wait  = wait_s & ~rst;

    // Address of the read in progress: live bus in IDLE, captured copy later.
    assign rd_addr_s = (state_r == IDLE) ? bus_a : rd_addr_r;

`ifdef SRAM_BRIDGE_BLOCKING_EN
    assign rd_ok_s = ~((rd_addr_s == A_DATA) & rx_empty_s);
`else
    assign rd_ok_s = 1'b1;
`endif

    // FSM next-state logic, wait-state handshake and access strobes
    always_comb begin
        next_state_s = state_r;
        wait_s       = 1'b0;
        rd_fire_s    = 1'b0;
        wr_fire_s    = 1'b0;
        stall_push_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus_cs & bus_oe) begin
                    wait_s = 1'b1;
                    if (WS_ONE && rd_ok_s) begin
                        rd_fire_s    = 1'b1;
                        next_state_s = RD_DONE;
                    end else begin
                        next_state_s = RD_WAIT;
                    end
                end else if (bus_cs & bus_we) begin
                    wr_fire_s = 1'b1;
`ifdef SRAM_BRIDGE_BLOCKING_EN
                    if ((bus_a == A_DATA) & tx_full_s & ~tx_pop_s) begin
                        next_state_s = WR_STALL;
                    end else begin
                        next_state_s = IDLE;
                    end
`else
                    next_state_s = IDLE;
`endif
                end else begin
                    next_state_s = IDLE;
                end
            end
            RD_WAIT: begin
                wait_s = 1'b1;
                if ((ws_cnt_r == WS_W'(1)) && rd_ok_s) begin
                    rd_fire_s    = 1'b1;
                    next_state_s = RD_DONE;
                end else begin
                    next_state_s = RD_WAIT;
                end
            end
            RD_DONE: begin
                next_state_s = IDLE;
            end
            WR_STALL: begin
                wait_s = 1'b1;
                if (tx_pop_s) begin
                    stall_push_s = 1'b1;
                    next_state_s = IDLE;
                end else begin
                    next_state_s = WR_STALL;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Read data multiplexer over the register window
    always_comb begin
        rd_val_s = 8'h00;
        case (rd_addr_s)
            A_DATA: begin
                if (rx_empty_s) begin
                    rd_val_s = 8'h00;
                end else begin
                    rd_val_s = rx_mem[rx_rd_ptr_r];
                end
            end
            A_STATUS: rd_val_s = {2'b00, tx_overflow_r, rx_underflow_r, irq_r,
                                  tx_empty_s, ~tx_full_s, ~rx_empty_s};
            A_COUNT:  rd_val_s = 8'(rx_count_r);
            A_CTRL:   rd_val_s = {6'b000000, ctrl_r};
            default:  rd_val_s = 8'h00;
        endcase
    end

    // FIFO push/pop qualification, flush and sticky-flag events
    always_comb begin
        flush_s      = wr_fire_s & (bus_a == A_CTRL) & bus_d_in[7];
        rx_push_s    = in_valid & in_ready & ~flush_s;
        rx_pop_s     = rd_fire_s & (rd_addr_s == A_DATA) & ~rx_empty_s;
        tx_pop_s     = out_valid & out_ready;
        sticky_clr_s = rd_fire_s & (rd_addr_s == A_STATUS);
`ifdef SRAM_BRIDGE_BLOCKING_EN
        tx_push_data_s = stall_push_s ? wr_data_r : bus_d_in;
        unf_set_s      = 1'b0;
        ovf_set_s      = 1'b0;
`else
        tx_push_data_s = bus_d_in;
        unf_set_s      = rd_fire_s & (rd_addr_s == A_DATA) & rx_empty_s;
        ovf_set_s      = wr_fire_s & (bus_a == A_DATA) & tx_full_s & ~tx_pop_s;
`endif
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        tx_push_s = (wr_fire_s & (bus_a == A_DATA) & (~tx_full_s | tx_pop_s))
                    | stall_push_s;
    end

    // RX FIFO storage write (no reset needed: guarded by occupancy)
    always_ff @(posedge clk) begin
        if (rx_push_s) begin
            rx_mem[rx_wr_ptr_r] <= in_data;
        end
    end

    // TX FIFO storage write
    always_ff @(posedge clk) begin
        if (tx_push_s) begin
            tx_mem[tx_wr_ptr_r] <= tx_push_data_s;
        end
    end

    // RX pointers and occupancy; flush empties the FIFO
    always_ff @(posedge clk) begin
        if (rst || flush_s) begin
            rx_wr_ptr_r <= {RX_AW{1'b0}};
            rx_rd_ptr_r <= {RX_AW{1'b0}};
            rx_count_r  <= {RX_CW{1'b0}};
        end else begin
            if (rx_push_s) rx_wr_ptr_r <= rx_wr_ptr_r + RX_AW'(1);
            if (rx_pop_s)  rx_rd_ptr_r <= rx_rd_ptr_r + RX_AW'(1);
            case ({rx_push_s, rx_pop_s})
                2'b10:   rx_count_r <= rx_count_r + RX_CW'(1);
                2'b01:   rx_count_r <= rx_count_r - RX_CW'(1);
                default: rx_count_r <= rx_count_r;
            endcase
        end
    end

    // TX pointers and occupancy; flush empties the FIFO
    always_ff @(posedge clk) begin
        if (rst || flush_s) begin
            tx_wr_ptr_r <= {TX_AW{1'b0}};
            tx_rd_ptr_r <= {TX_AW{1'b0}};
            tx_count_r  <= {TX_CW{1'b0}};
        end else begin
            if (tx_push_s) tx_wr_ptr_r <= tx_wr_ptr_r + TX_AW'(1);
            if (tx_pop_s)  tx_rd_ptr_r <= tx_rd_ptr_r + TX_AW'(1);
            case ({tx_push_s, tx_pop_s})
                2'b10:   tx_count_r <= tx_count_r + TX_CW'(1);
                2'b01:   tx_count_r <= tx_count_r - TX_CW'(1);
                default: tx_count_r <= tx_count_r;
            endcase
        end
    end

    // Read sequencing: capture address, count wait cycles, latch read data
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_addr_r   <= 2'd0;
            ws_cnt_r    <= {WS_W{1'b0}};
            bus_d_out_r <= 8'h00;
        end else begin
            if ((state_r == IDLE) && bus_cs && bus_oe) begin
                rd_addr_r <= bus_a;
                ws_cnt_r  <= WS_W'(WS_INIT);
            end else if ((state_r == RD_WAIT) && (ws_cnt_r > WS_W'(1))) begin
                ws_cnt_r  <= ws_cnt_r - WS_W'(1);
            end else begin
                ws_cnt_r  <= ws_cnt_r;
            end
            if (rd_fire_s) begin
                bus_d_out_r <= rd_val_s;
            end
        end
    end

`ifdef SRAM_BRIDGE_BLOCKING_EN
    // Hold the write byte while a full-FIFO write is stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_data_r <= 8'h00;
        end else if (wr_fire_s) begin
            wr_data_r <= bus_d_in;
        end
    end
`endif

    // CTRL enables, sticky error flags and the registered interrupt
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_r         <= 2'b00;
            rx_underflow_r <= 1'b0;
            tx_overflow_r  <= 1'b0;
            irq_r          <= 1'b0;
        end else begin
            if (wr_fire_s && (bus_a == A_CTRL)) begin
                ctrl_r <= bus_d_in[1:0];
            end
            rx_underflow_r <= (rx_underflow_r & ~sticky_clr_s) | unf_set_s;
            tx_overflow_r  <= (tx_overflow_r  & ~sticky_clr_s) | ovf_set_s;
            irq_r <= (ctrl_r[0] & ~rx_empty_s) | (ctrl_r[1] & tx_empty_s)
                     | rx_underflow_r | tx_overflow_r;
        end
    end

endmodule
